// File: rtl/control_pkg.sv
// Control encodings shared by the decode stage and downstream pipeline stages,
// plus the ID/EX pipeline register layout.
package control_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    ALU_A_RS1  = 2'd0,
    ALU_A_PC   = 2'd1,
    ALU_A_ZERO = 2'd2
  } alu_a_e;

  typedef enum logic {
    ALU_B_RS2 = 1'b0,
    ALU_B_IMM = 1'b1
  } alu_b_e;

  typedef enum logic [1:0] {
    COND_NEVER    = 2'd0,
    COND_ALWAYS   = 2'd1,
    COND_ZERO     = 2'd2,
    COND_NOT_ZERO = 2'd3
  } cond_e;

  typedef enum logic [1:0] {
    RD_SRC_ALU  = 2'd0,
    RD_SRC_PC_4 = 2'd1,
    RD_SRC_DMEM = 2'd2,
    RD_SRC_CSR  = 2'd3
  } rd_src_e;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2
  } width_e;

  typedef enum logic [1:0] {
    CSR_NOP = 2'd0,
    CSR_RW  = 2'd1,
    CSR_RS  = 2'd2,
    CSR_RC  = 2'd3
  } csr_op_e;

  typedef enum logic {
    JUMP_BASE_PC  = 1'b0,
    JUMP_BASE_RS1 = 1'b1
  } jump_base_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] INS_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INS_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INS_MRET   = 32'h3020_0073;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    alu_op_e     alu_op;
    alu_a_e      alu_a_src;
    alu_b_e      alu_b_src;
    width_e      dmem_width;
    logic        dmem_zero_ext;
    logic        dmem_read;
    logic        dmem_write;
    jump_base_e  jump_base_src;
    cond_e       jump_cond;
    logic        rd_wen;
    rd_src_e     rd_src;
    logic [11:0] csr_addr;
    csr_op_e     csr_op;
    logic        csr_src;
    logic        ins_misalign;
    logic        ins_illegal;
    logic        ecall;
    logic        ebreak;
    logic        trap_return;
  } id_ex_t;

  // alt selects SUB over ADD and SRA over SRL (instruction bit 30)
  function automatic alu_op_e alu_op_from_funct(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// 32x32 integer register file: two combinational read ports, one write port,
// x0 hardwired to zero, same-cycle write-through to the read ports.
module register_file (
  input  logic        clk,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (wen && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    if (raddr1 == 5'd0) begin
      rdata1 = '0;
    end else if (wen && (waddr == raddr1)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs[raddr1];
    end
  end

  always_comb begin
    if (raddr2 == 5'd0) begin
      rdata2 = '0;
    end else if (wen && (waddr == raddr2)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs[raddr2];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register file read, control decode, load-use hazard
// detection and the ID/EX pipeline register.
module decode_stage
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_flush,
  input  logic [31:0] if_id__ins,
  input  logic [31:0] if_id__pc,
  input  logic        if_id__ins_misalign,
  input  logic        if_id__data_hazard,
  input  logic        wb_id__rd_wen,
  input  logic [4:0]  wb_id__rd_addr,
  input  logic [31:0] wb_id__rd_wdata,
  output logic [31:0] id_ex__pc,
  output logic [31:0] id_ex__imm,
  output logic [31:0] id_ex__rs1_rdata,
  output logic [31:0] id_ex__rs2_rdata,
  output logic [4:0]  id_ex__rs1_addr,
  output logic [4:0]  id_ex__rs2_addr,
  output logic [4:0]  id_ex__rd_addr,
  output logic [3:0]  id_ex__alu_op,
  output logic [1:0]  id_ex__alu_a_src,
  output logic        id_ex__alu_b_src,
  output logic [1:0]  id_ex__dmem_width,
  output logic        id_ex__dmem_zero_ext,
  output logic        id_ex__dmem_read,
  output logic        id_ex__dmem_write,
  output logic        id_ex__jump_base_src,
  output logic [1:0]  id_ex__jump_cond,
  output logic        id_ex__rd_wen,
  output logic [1:0]  id_ex__rd_src,
  output logic [11:0] id_ex__csr_addr,
  output logic [1:0]  id_ex__csr_op,
  output logic        id_ex__csr_src,
  output logic        id_ex__ins_misalign,
  output logic        id_ex__ins_illegal,
  output logic        id_ex__ecall,
  output logic        id_ex__ebreak,
  output logic        id_ex__trap_return,
  output logic        data_hazard
);

  logic [31:0] ins;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
  logic [31:0] rs1_rdata, rs2_rdata;
  logic        legal, uses_rs1, uses_rs2;
  id_ex_t      dec;
  id_ex_t      id_ex_q;

  assign ins    = if_id__ins;
  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];
  assign funct7 = ins[31:25];
  assign rs1    = ins[19:15];
  assign rs2    = ins[24:20];
  assign rd     = ins[11:7];

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign imm_z = {27'b0, ins[19:15]};

  register_file u_register_file (
    .clk    (clk),
    .wen    (wb_id__rd_wen),
    .waddr  (wb_id__rd_addr),
    .wdata  (wb_id__rd_wdata),
    .raddr1 (rs1),
    .rdata1 (rs1_rdata),
    .raddr2 (rs2),
    .rdata2 (rs2_rdata)
  );

  always_comb begin
    dec           = '0;
    legal         = 1'b1;
    uses_rs1      = 1'b0;
    uses_rs2      = 1'b0;
    dec.pc        = if_id__pc;
    dec.rs1_addr  = rs1;
    dec.rs2_addr  = rs2;
    dec.rd_addr   = rd;
    dec.rs1_rdata = rs1_rdata;
    dec.rs2_rdata = rs2_rdata;
    dec.csr_addr  = ins[31:20];

    case (opcode)
      OPC_OP: begin
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        legal         = (funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec.alu_op    = alu_op_from_funct(funct3, ins[30]);
        dec.alu_b_src = ALU_B_RS2;
        dec.rd_wen    = 1'b1;
      end
      OPC_OP_IMM: begin
        uses_rs1      = 1'b1;
        if (funct3 == 3'b001) begin
          legal = (funct7 == F7_BASE);
        end else if (funct3 == 3'b101) begin
          legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        end
        dec.alu_op    = alu_op_from_funct(funct3, (funct3 == 3'b101) && ins[30]);
        dec.alu_b_src = ALU_B_IMM;
        dec.imm       = imm_i;
        dec.rd_wen    = 1'b1;
      end
      OPC_LUI: begin
        dec.alu_a_src = ALU_A_ZERO;
        dec.alu_b_src = ALU_B_IMM;
        dec.imm       = imm_u;
        dec.rd_wen    = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_a_src = ALU_A_PC;
        dec.alu_b_src = ALU_B_IMM;
        dec.imm       = imm_u;
        dec.rd_wen    = 1'b1;
      end
      OPC_JAL: begin
        dec.imm           = imm_j;
        dec.jump_cond     = COND_ALWAYS;
        dec.jump_base_src = JUMP_BASE_PC;
        dec.rd_src        = RD_SRC_PC_4;
        dec.rd_wen        = 1'b1;
      end
      OPC_JALR: begin
        uses_rs1          = 1'b1;
        legal             = (funct3 == 3'b000);
        dec.imm           = imm_i;
        dec.jump_cond     = COND_ALWAYS;
        dec.jump_base_src = JUMP_BASE_RS1;
        dec.rd_src        = RD_SRC_PC_4;
        dec.rd_wen        = 1'b1;
      end
      OPC_BRANCH: begin
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        legal         = (funct3[2:1] != 2'b01);
        dec.imm       = imm_b;
        dec.alu_b_src = ALU_B_RS2;
        // EQ/NE test the difference; LT/GE test the set-less-than result
        if (funct3[2] == 1'b0) begin
          dec.alu_op    = ALU_SUB;
          dec.jump_cond = funct3[0] ? COND_NOT_ZERO : COND_ZERO;
        end else begin
          dec.alu_op    = funct3[1] ? ALU_SLTU : ALU_SLT;
          dec.jump_cond = funct3[0] ? COND_ZERO : COND_NOT_ZERO;
        end
      end
      OPC_LOAD: begin
        uses_rs1          = 1'b1;
        legal             = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                            (funct3 == 3'b100) || (funct3 == 3'b101);
        dec.alu_b_src     = ALU_B_IMM;
        dec.imm           = imm_i;
        dec.dmem_read     = 1'b1;
        dec.dmem_zero_ext = funct3[2];
        dec.rd_src        = RD_SRC_DMEM;
        dec.rd_wen        = 1'b1;
        case (funct3[1:0])
          2'b00:   dec.dmem_width = WIDTH_BYTE;
          2'b01:   dec.dmem_width = WIDTH_HALF;
          default: dec.dmem_width = WIDTH_WORD;
        endcase
      end
      OPC_STORE: begin
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
        legal          = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        dec.alu_b_src  = ALU_B_IMM;
        dec.imm        = imm_s;
        dec.dmem_write = 1'b1;
        case (funct3[1:0])
          2'b00:   dec.dmem_width = WIDTH_BYTE;
          2'b01:   dec.dmem_width = WIDTH_HALF;
          default: dec.dmem_width = WIDTH_WORD;
        endcase
      end
      OPC_MISC_MEM: begin
        legal = (funct3 == 3'b000);
      end
      OPC_SYSTEM: begin
        case (funct3)
          3'b000: begin
            if (ins == INS_ECALL) begin
              dec.ecall = 1'b1;
            end else if (ins == INS_EBREAK) begin
              dec.ebreak = 1'b1;
            end else if (ins == INS_MRET) begin
              dec.trap_return = 1'b1;
            end else begin
              legal = 1'b0;
            end
          end
          3'b100: legal = 1'b0;
          default: begin
            // funct3[1:0] maps directly onto RW/RS/RC; funct3[2] picks zimm
            dec.csr_op  = csr_op_e'(funct3[1:0]);
            dec.csr_src = funct3[2];
            dec.rd_src  = RD_SRC_CSR;
            dec.rd_wen  = 1'b1;
            if (funct3[2]) begin
              dec.imm = imm_z;
            end else begin
              uses_rs1 = 1'b1;
            end
          end
        endcase
      end
      default: legal = 1'b0;
    endcase

    if (!legal || if_id__ins_misalign) begin
      dec.rd_wen      = 1'b0;
      dec.dmem_read   = 1'b0;
      dec.dmem_write  = 1'b0;
      dec.jump_cond   = COND_NEVER;
      dec.csr_op      = CSR_NOP;
      dec.ecall       = 1'b0;
      dec.ebreak      = 1'b0;
      dec.trap_return = 1'b0;
    end
    dec.ins_misalign = if_id__ins_misalign;
    dec.ins_illegal  = !legal && !if_id__ins_misalign;
    if (rd == 5'd0) begin
      dec.rd_wen = 1'b0;
    end
  end

  // A stalled instruction comes back flagged so the stall is never repeated
  assign data_hazard = id_ex_q.dmem_read && (id_ex_q.rd_addr != 5'd0) &&
                       ((uses_rs1 && (rs1 == id_ex_q.rd_addr)) ||
                        (uses_rs2 && (rs2 == id_ex_q.rd_addr))) &&
                       !if_id__data_hazard;

  always_ff @(posedge clk) begin
    if (rst || pipe_flush || data_hazard) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= dec;
    end
  end

  assign id_ex__pc            = id_ex_q.pc;
  assign id_ex__imm           = id_ex_q.imm;
  assign id_ex__rs1_rdata     = id_ex_q.rs1_rdata;
  assign id_ex__rs2_rdata     = id_ex_q.rs2_rdata;
  assign id_ex__rs1_addr      = id_ex_q.rs1_addr;
  assign id_ex__rs2_addr      = id_ex_q.rs2_addr;
  assign id_ex__rd_addr       = id_ex_q.rd_addr;
  assign id_ex__alu_op        = id_ex_q.alu_op;
  assign id_ex__alu_a_src     = id_ex_q.alu_a_src;
  assign id_ex__alu_b_src     = id_ex_q.alu_b_src;
  assign id_ex__dmem_width    = id_ex_q.dmem_width;
  assign id_ex__dmem_zero_ext = id_ex_q.dmem_zero_ext;
  assign id_ex__dmem_read     = id_ex_q.dmem_read;
  assign id_ex__dmem_write    = id_ex_q.dmem_write;
  assign id_ex__jump_base_src = id_ex_q.jump_base_src;
  assign id_ex__jump_cond     = id_ex_q.jump_cond;
  assign id_ex__rd_wen        = id_ex_q.rd_wen;
  assign id_ex__rd_src        = id_ex_q.rd_src;
  assign id_ex__csr_addr      = id_ex_q.csr_addr;
  assign id_ex__csr_op        = id_ex_q.csr_op;
  assign id_ex__csr_src       = id_ex_q.csr_src;
  assign id_ex__ins_misalign  = id_ex_q.ins_misalign;
  assign id_ex__ins_illegal   = id_ex_q.ins_illegal;
  assign id_ex__ecall         = id_ex_q.ecall;
  assign id_ex__ebreak        = id_ex_q.ebreak;
  assign id_ex__trap_return   = id_ex_q.trap_return;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected ID/EX contents are queued when an
// instruction is presented and compared one edge later.
module tb_decode_stage;
  import control_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_flush = 1'b0;
  logic [31:0] if_id__ins = 32'h0000_0013;
  logic [31:0] if_id__pc = '0;
  logic        if_id__ins_misalign = 1'b0;
  logic        if_id__data_hazard = 1'b0;
  logic        wb_id__rd_wen = 1'b0;
  logic [4:0]  wb_id__rd_addr = '0;
  logic [31:0] wb_id__rd_wdata = '0;
  logic [31:0] id_ex__pc, id_ex__imm, id_ex__rs1_rdata, id_ex__rs2_rdata;
  logic [4:0]  id_ex__rs1_addr, id_ex__rs2_addr, id_ex__rd_addr;
  logic [3:0]  id_ex__alu_op;
  logic [1:0]  id_ex__alu_a_src;
  logic        id_ex__alu_b_src;
  logic [1:0]  id_ex__dmem_width;
  logic        id_ex__dmem_zero_ext, id_ex__dmem_read, id_ex__dmem_write;
  logic        id_ex__jump_base_src;
  logic [1:0]  id_ex__jump_cond;
  logic        id_ex__rd_wen;
  logic [1:0]  id_ex__rd_src;
  logic [11:0] id_ex__csr_addr;
  logic [1:0]  id_ex__csr_op;
  logic        id_ex__csr_src;
  logic        id_ex__ins_misalign, id_ex__ins_illegal, id_ex__ecall, id_ex__ebreak;
  logic        id_ex__trap_return;
  logic        data_hazard;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .pipe_flush(pipe_flush),
    .if_id__ins(if_id__ins), .if_id__pc(if_id__pc),
    .if_id__ins_misalign(if_id__ins_misalign), .if_id__data_hazard(if_id__data_hazard),
    .wb_id__rd_wen(wb_id__rd_wen), .wb_id__rd_addr(wb_id__rd_addr),
    .wb_id__rd_wdata(wb_id__rd_wdata),
    .id_ex__pc(id_ex__pc), .id_ex__imm(id_ex__imm),
    .id_ex__rs1_rdata(id_ex__rs1_rdata), .id_ex__rs2_rdata(id_ex__rs2_rdata),
    .id_ex__rs1_addr(id_ex__rs1_addr), .id_ex__rs2_addr(id_ex__rs2_addr),
    .id_ex__rd_addr(id_ex__rd_addr), .id_ex__alu_op(id_ex__alu_op),
    .id_ex__alu_a_src(id_ex__alu_a_src), .id_ex__alu_b_src(id_ex__alu_b_src),
    .id_ex__dmem_width(id_ex__dmem_width), .id_ex__dmem_zero_ext(id_ex__dmem_zero_ext),
    .id_ex__dmem_read(id_ex__dmem_read), .id_ex__dmem_write(id_ex__dmem_write),
    .id_ex__jump_base_src(id_ex__jump_base_src), .id_ex__jump_cond(id_ex__jump_cond),
    .id_ex__rd_wen(id_ex__rd_wen), .id_ex__rd_src(id_ex__rd_src),
    .id_ex__csr_addr(id_ex__csr_addr), .id_ex__csr_op(id_ex__csr_op),
    .id_ex__csr_src(id_ex__csr_src), .id_ex__ins_misalign(id_ex__ins_misalign),
    .id_ex__ins_illegal(id_ex__ins_illegal), .id_ex__ecall(id_ex__ecall),
    .id_ex__ebreak(id_ex__ebreak), .id_ex__trap_return(id_ex__trap_return),
    .data_hazard(data_hazard)
  );

  typedef struct {
    logic        chk, chk_alu, chk_imm, chk_rd;
    logic [31:0] pc, imm, r1, r2;
    logic [3:0]  alu;
    logic [1:0]  a;
    logic        b;
    logic [4:0]  rd;
    logic        wen;
    logic [1:0]  rd_src;
    logic        ld, st;
    logic [1:0]  width;
    logic        zext, base;
    logic [1:0]  cond, csr_op;
    logic        csr_src;
    logic [11:0] csr_addr;
    logic        ill, ecall, ebreak, mret, mis;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] regs [32];
  logic [31:0] pc_cur = 32'h0000_0100;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t bub();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  function automatic exp_t dat(input logic [31:0] imm, input logic [3:0] alu, input logic [1:0] a,
                               input logic b, input logic [4:0] rd, input logic wen,
                               input logic [1:0] rd_src);
    exp_t e;
    e = bub();
    e.chk = 1'b1; e.chk_alu = 1'b1; e.chk_imm = 1'b1; e.chk_rd = 1'b1;
    e.imm = imm; e.alu = alu; e.a = a; e.b = b; e.rd = rd; e.wen = wen; e.rd_src = rd_src;
    return e;
  endfunction

  // Register read as seen in the decode cycle, including same-cycle writeback
  function automatic logic [31:0] reg_model(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wb_id__rd_wen && (wb_id__rd_addr == a)) return wb_id__rd_wdata;
    return regs[a];
  endfunction

  task automatic compare(input string tag, input exp_t e);
    check({tag, "/jump_cond"}, id_ex__jump_cond, e.cond);
    check({tag, "/rd_wen"}, id_ex__rd_wen, e.wen);
    check({tag, "/dmem_read"}, id_ex__dmem_read, e.ld);
    check({tag, "/dmem_write"}, id_ex__dmem_write, e.st);
    check({tag, "/csr_op"}, id_ex__csr_op, e.csr_op);
    check({tag, "/illegal"}, id_ex__ins_illegal, e.ill);
    check({tag, "/ecall"}, id_ex__ecall, e.ecall);
    check({tag, "/ebreak"}, id_ex__ebreak, e.ebreak);
    check({tag, "/trap_return"}, id_ex__trap_return, e.mret);
    check({tag, "/misalign"}, id_ex__ins_misalign, e.mis);
    if (e.chk) begin
      check({tag, "/pc"}, id_ex__pc, e.pc);
      check({tag, "/rs1_rdata"}, id_ex__rs1_rdata, e.r1);
      check({tag, "/rs2_rdata"}, id_ex__rs2_rdata, e.r2);
    end
    if (e.chk_alu) begin
      check({tag, "/alu_op"}, id_ex__alu_op, e.alu);
      check({tag, "/alu_a"}, id_ex__alu_a_src, e.a);
      check({tag, "/alu_b"}, id_ex__alu_b_src, e.b);
    end
    if (e.chk_imm) check({tag, "/imm"}, id_ex__imm, e.imm);
    if (e.chk_rd) check({tag, "/rd_addr"}, id_ex__rd_addr, e.rd);
    if (e.wen) check({tag, "/rd_src"}, id_ex__rd_src, e.rd_src);
    if (e.cond != 2'd0) check({tag, "/jump_base"}, id_ex__jump_base_src, e.base);
    if (e.ld || e.st) check({tag, "/width"}, id_ex__dmem_width, e.width);
    if (e.ld) check({tag, "/zero_ext"}, id_ex__dmem_zero_ext, e.zext);
    if (e.csr_op != 2'd0) begin
      check({tag, "/csr_src"}, id_ex__csr_src, e.csr_src);
      check({tag, "/csr_addr"}, id_ex__csr_addr, e.csr_addr);
    end
  endtask

  // Sideband inputs (flush, echo, misalign, writeback, rst) are set by the caller
  task automatic step(input string tag, input logic [31:0] ins, input exp_t e_in, input logic hz);
    exp_t e;
    e = e_in;
    @(negedge clk);
    if_id__ins = ins;
    if_id__pc  = pc_cur;
    e.pc = pc_cur;
    e.r1 = reg_model(ins[19:15]);
    e.r2 = reg_model(ins[24:20]);
    #1;
    check({tag, "/data_hazard"}, data_hazard, hz);
    sb_q.push_back(e);
    @(posedge clk);
    if (wb_id__rd_wen && (wb_id__rd_addr != 5'd0)) regs[wb_id__rd_addr] = wb_id__rd_wdata;
    #1;
    compare(tag, sb_q.pop_front());
    wb_id__rd_wen = 1'b0;
    pipe_flush = 1'b0;
    if_id__data_hazard = 1'b0;
    if_id__ins_misalign = 1'b0;
    rst = 1'b0;
    pc_cur = pc_cur + 32'd4;
  endtask

  exp_t e;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst/pc", id_ex__pc, 32'h0);
    check("rst/imm", id_ex__imm, 32'h0);
    check("rst/rd_wen", id_ex__rd_wen, 32'h0);
    check("rst/dmem_read", id_ex__dmem_read, 32'h0);
    check("rst/jump_cond", id_ex__jump_cond, 32'h0);
    check("rst/csr_op", id_ex__csr_op, 32'h0);
    check("rst/rd_addr", id_ex__rd_addr, 32'h0);
    rst = 1'b0;

    for (int i = 1; i < 32; i++) begin
      wb_id__rd_wen = 1'b1;
      wb_id__rd_addr = 5'(i);
      wb_id__rd_wdata = 32'hA500_0000 + 32'(i);
      step("preload", 32'h0000_0013, dat(0, ALU_ADD, ALU_A_RS1, ALU_B_IMM, 0, 0, RD_SRC_ALU), 0);
    end

    step("addi", 32'h0050_0093, dat(5, ALU_ADD, ALU_A_RS1, ALU_B_IMM, 1, 1, RD_SRC_ALU), 0);

    wb_id__rd_wen = 1'b1; wb_id__rd_addr = 5'd2; wb_id__rd_wdata = 32'hDEAD_BEEF;
    e = dat(0, ALU_ADD, ALU_A_RS1, ALU_B_RS2, 3, 1, RD_SRC_ALU); e.chk_imm = 0;
    step("add_bypass", 32'h0021_01B3, e, 0);
    check("bypass/rs1_value", id_ex__rs1_rdata, 32'hDEAD_BEEF);

    e = dat(0, ALU_SUB, ALU_A_RS1, ALU_B_RS2, 4, 1, RD_SRC_ALU); e.chk_imm = 0;
    step("sub", 32'h4011_8233, e, 0);

    e = dat(0, ALU_ADD, ALU_A_RS1, ALU_B_IMM, 5, 1, RD_SRC_DMEM); e.ld = 1; e.width = 2;
    step("lw", 32'h0000_A283, e, 0);
    step("addi_unused_rs2", 32'h0050_0393, dat(5, ALU_ADD, ALU_A_RS1, ALU_B_IMM, 7, 1, RD_SRC_ALU), 0);
    step("lw2", 32'h0000_A283, e, 0);
    step("load_use", 32'h0002_8333, bub(), 1);
    step("lw3", 32'h0000_A283, e, 0);
    if_id__data_hazard = 1'b1;
    begin
      exp_t ea;
      ea = dat(0, ALU_ADD, ALU_A_RS1, ALU_B_RS2, 6, 1, RD_SRC_ALU); ea.chk_imm = 0;
      step("load_use_echo", 32'h0002_8333, ea, 0);
    end
    step("lw4", 32'h0000_A283, e, 0);
    pipe_flush = 1'b1;
    step("flush_and_hazard", 32'h0002_8333, bub(), 1);
    step("after_flush", 32'h0050_0393, dat(5, ALU_ADD, ALU_A_RS1, ALU_B_IMM, 7, 1, RD_SRC_ALU), 0);

    pipe_flush = 1'b1;
    step("flush_beq", 32'h0020_8463, bub(), 0);
    e = dat(8, ALU_SUB, ALU_A_RS1, ALU_B_RS2, 0, 0, RD_SRC_ALU); e.chk_rd = 0; e.cond = 2; e.base = 0;
    step("beq", 32'h0020_8463, e, 0);
    e = dat(8, ALU_SLT, ALU_A_RS1, ALU_B_RS2, 0, 0, RD_SRC_ALU); e.chk_rd = 0; e.cond = 2; e.base = 0;
    step("bge", 32'h0020_D463, e, 0);
    e = dat(32'hFFFF_FFFC, ALU_SLTU, ALU_A_RS1, ALU_B_RS2, 0, 0, RD_SRC_ALU);
    e.chk_rd = 0; e.cond = 3; e.base = 0;
    step("bltu", 32'hFE20_EEE3, e, 0);

    e = dat(16, 0, 0, 0, 1, 1, RD_SRC_PC_4); e.chk_alu = 0; e.cond = 1; e.base = 0;
    step("jal", 32'h0100_00EF, e, 0);
    e = dat(0, 0, 0, 0, 0, 0, RD_SRC_PC_4); e.chk_alu = 0; e.cond = 1; e.base = 1;
    step("jalr_x0", 32'h0000_8067, e, 0);

    e = dat(12, ALU_ADD, ALU_A_RS1, ALU_B_IMM, 0, 0, RD_SRC_ALU); e.chk_rd = 0; e.st = 1; e.width = 2;
    step("sw", 32'h0020_A623, e, 0);
    e = dat(32'hFFFF_FFFF, ALU_ADD, ALU_A_RS1, ALU_B_IMM, 8, 1, RD_SRC_DMEM);
    e.ld = 1; e.width = 0; e.zext = 1;
    step("lbu", 32'hFFF0_C403, e, 0);
    step("lui", 32'h1234_54B7, dat(32'h1234_5000, ALU_ADD, ALU_A_ZERO, ALU_B_IMM, 9, 1, RD_SRC_ALU), 0);
    step("auipc", 32'h0000_1517, dat(32'h0000_1000, ALU_ADD, ALU_A_PC, ALU_B_IMM, 10, 1, RD_SRC_ALU), 0);

    e = dat(0, 0, 0, 0, 11, 1, RD_SRC_CSR); e.chk_alu = 0; e.chk_imm = 0;
    e.csr_op = 1; e.csr_src = 0; e.csr_addr = 12'h305;
    step("csrrw", 32'h3050_95F3, e, 0);
    e = dat(8, 0, 0, 0, 0, 0, RD_SRC_CSR); e.chk_alu = 0;
    e.csr_op = 3; e.csr_src = 1; e.csr_addr = 12'h300;
    step("csrrci", 32'h3004_7073, e, 0);

    e = bub(); e.ill = 1;
    step("all_ones", 32'hFFFF_FFFF, e, 0);
    step("mul_funct7", 32'h0220_81B3, e, 0);
    e = bub(); e.ecall = 1;
    step("ecall", 32'h0000_0073, e, 0);
    e = bub(); e.ebreak = 1;
    step("ebreak", 32'h0010_0073, e, 0);
    e = bub(); e.mret = 1;
    step("mret", 32'h3020_0073, e, 0);
    if_id__ins_misalign = 1'b1;
    e = bub(); e.mis = 1;
    step("misalign", 32'h0050_0093, e, 0);

    wb_id__rd_wen = 1'b1; wb_id__rd_addr = 5'd0; wb_id__rd_wdata = 32'h0000_FFFF;
    e = dat(0, ALU_ADD, ALU_A_RS1, ALU_B_RS2, 3, 1, RD_SRC_ALU); e.chk_imm = 0;
    step("x0_write", 32'h0000_01B3, e, 0);
    step("x0_after", 32'h0000_01B3, e, 0);

    rst = 1'b1;
    step("rst_mid", 32'h0050_0093, bub(), 0);
    check("rst_mid/pc", id_ex__pc, 32'h0);
    check("rst_mid/imm", id_ex__imm, 32'h0);
    check("rst_mid/rd_addr", id_ex__rd_addr, 32'h0);
    step("post_rst", 32'h0050_0093, dat(5, ALU_ADD, ALU_A_RS1, ALU_B_IMM, 1, 1, RD_SRC_ALU), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
